// File: rtl/alu_pkg.sv
// Shared opcodes, state encoding and response entry for the compare-ALU issuer.
package alu_pkg;
    localparam int DEF_WIDTH = 32;
    localparam int DEF_TAG_W = 4;

    typedef logic [2:0] opcode_t;
    localparam opcode_t OP_GT = 3'b010;
    localparam opcode_t OP_LT = 3'b011;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } issuer_state_e;

    typedef struct packed {
        logic [DEF_WIDTH-1:0] result;
        logic [DEF_TAG_W-1:0] tag;
        logic                 err;
    } resp_entry_t;

    function automatic logic op_unsupported(input opcode_t op);
        return (op != OP_GT) && (op != OP_LT);
    endfunction
endpackage

// File: rtl/alu_resp_fifo.sv
// In-order response buffer; head is valid whenever count is non-zero.
module alu_resp_fifo
    import alu_pkg::*;
#(
    parameter int  DEPTH   = 2,
    parameter type entry_t = resp_entry_t,
    localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  entry_t           push_data,
    input  logic             pop,
    output entry_t           head,
    output logic             empty,
    output logic [CNT_W-1:0] count
);
    entry_t           mem_q [DEPTH];
    entry_t           mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign count   = count_q;
    assign head    = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ptr_next(wr_ptr_q);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop) begin
            rd_ptr_d = ptr_next(rd_ptr_q);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Buffer registers; reset clears contents so the idle head reads as zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

// File: rtl/alu_cmd_issuer.sv
// Issues one tagged compare at a time to the ALU, waits LATENCY cycles, and
// queues the captured result with its tag for the consumer.
module alu_cmd_issuer
    import alu_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int TAG_W      = DEF_TAG_W,
    parameter int LATENCY    = 0,
    parameter int RESP_DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [2:0]       req_op,
    input  logic [TAG_W-1:0] req_tag,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_opcode,
    input  logic [WIDTH-1:0] alu_result,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_result,
    output logic [TAG_W-1:0] resp_tag,
    output logic             resp_err,
    output logic             busy
);
    localparam int CNT_W = $clog2(RESP_DEPTH + 1);

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic [TAG_W-1:0] tag;
        logic             err;
    } entry_t;

    issuer_state_e    state_q, state_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    opcode_t          alu_op_q, alu_op_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             err_q, err_d;
    logic             req_fire;
    logic             capture;
    logic             resp_pop;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    entry_t           push_entry;
    entry_t           head_entry;

    // Accept only with a guaranteed free slot, so a capture can never overflow.
    assign req_ready  = !rst && (state_q == IDLE) && (fifo_count < CNT_W'(RESP_DEPTH));
    assign req_fire   = req_valid && req_ready;
    assign capture    = (state_q == WAIT) && (cnt_q == 3'(LATENCY));
    assign push_entry = '{result: alu_result, tag: tag_q, err: err_q};
    assign resp_pop   = resp_valid && resp_ready;

    // FSM next-state and operand/tag holding registers.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        alu_a_d  = alu_a_q;
        alu_b_d  = alu_b_q;
        alu_op_d = alu_op_q;
        tag_d    = tag_q;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                if (req_fire) begin
                    alu_a_d  = req_a;
                    alu_b_d  = req_b;
                    alu_op_d = req_op;
                    tag_d    = req_tag;
                    err_d    = op_unsupported(req_op);
                    cnt_d    = 3'd0;
                    state_d  = WAIT;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (capture) begin
                    cnt_d   = 3'd0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and ALU-facing registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= 3'd0;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            alu_op_q <= 3'b000;
            tag_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            alu_a_q  <= alu_a_d;
            alu_b_q  <= alu_b_d;
            alu_op_q <= alu_op_d;
            tag_q    <= tag_d;
            err_q    <= err_d;
        end
    end

    alu_resp_fifo #(
        .DEPTH   (RESP_DEPTH),
        .entry_t (entry_t)
    ) u_resp_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (capture),
        .push_data (push_entry),
        .pop       (resp_pop),
        .head      (head_entry),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_opcode  = alu_op_q;
    assign busy        = (state_q != IDLE);
    assign resp_valid  = !fifo_empty;
    assign resp_result = head_entry.result;
    assign resp_tag    = head_entry.tag;
    assign resp_err    = head_entry.err;
endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Bench for alu_cmd_issuer: one instance with LATENCY=0 and one with LATENCY=3,
// each driving a behavioural compare ALU, checked against a tag-ordered scoreboard.
module tb_alu_cmd_issuer;
    localparam int W  = 32;
    localparam int TW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  req_a, req_b;
    logic [2:0]    req_op;
    logic [TW-1:0] req_tag;
    logic          req_valid0, req_valid3, resp_ready;
    logic          req_ready0, req_ready3;
    logic [W-1:0]  alu_a0, alu_b0, alu_a3, alu_b3, alu_res0, alu_res3;
    logic [2:0]    alu_op0, alu_op3;
    logic          resp_valid0, resp_valid3, resp_err0, resp_err3, busy0, busy3;
    logic [W-1:0]  resp_result0, resp_result3;
    logic [TW-1:0] resp_tag0, resp_tag3;
    logic          glitch;
    logic          rand_rr;
    logic          fired0, fired3;

    logic [36:0]   q0[$];
    logic [36:0]   q3[$];
    int            checks = 0;
    int            errors = 0;
    int            n_req0 = 0, n_req3 = 0, n_resp0 = 0, n_resp3 = 0;

    always #5 clk = ~clk;

    function automatic logic [W-1:0] alu_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic [2:0] op);
        case (op)
            3'b010:  return {31'd0, a > b};
            3'b011:  return {31'd0, a < b};
            default: return 32'd0;
        endcase
    endfunction

    assign alu_res0 = alu_model(alu_a0, alu_b0, alu_op0);
    assign alu_res3 = glitch ? 32'hDEAD_BEEF : alu_model(alu_a3, alu_b3, alu_op3);

    alu_cmd_issuer #(.WIDTH(W), .TAG_W(TW), .LATENCY(0), .RESP_DEPTH(2)) u_dut0 (
        .clk(clk), .rst(rst), .req_valid(req_valid0), .req_ready(req_ready0),
        .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_tag(req_tag),
        .alu_a(alu_a0), .alu_b(alu_b0), .alu_opcode(alu_op0), .alu_result(alu_res0),
        .resp_valid(resp_valid0), .resp_ready(resp_ready), .resp_result(resp_result0),
        .resp_tag(resp_tag0), .resp_err(resp_err0), .busy(busy0)
    );

    alu_cmd_issuer #(.WIDTH(W), .TAG_W(TW), .LATENCY(3), .RESP_DEPTH(2)) u_dut3 (
        .clk(clk), .rst(rst), .req_valid(req_valid3), .req_ready(req_ready3),
        .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_tag(req_tag),
        .alu_a(alu_a3), .alu_b(alu_b3), .alu_opcode(alu_op3), .alu_result(alu_res3),
        .resp_valid(resp_valid3), .resp_ready(resp_ready), .resp_result(resp_result3),
        .resp_tag(resp_tag3), .resp_err(resp_err3), .busy(busy3)
    );

    // Expected response straight from the compare rules: unsigned GT/LT, else 0 with err.
    function automatic logic [36:0] ref_resp(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [2:0] op, input logic [TW-1:0] tag);
        logic [W-1:0] r;
        logic         e;
        r = 32'd0;
        e = 1'b1;
        if (op == 3'b010) begin
            e = 1'b0;
            r = (a > b) ? 32'd1 : 32'd0;
        end else if (op == 3'b011) begin
            e = 1'b0;
            r = (b > a) ? 32'd1 : 32'd0;
        end
        return {r, tag, e};
    endfunction

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    // One clock: observe handshakes just before the edge, return #1 after it.
    task automatic tick();
        @(negedge clk);
        fired0 = 1'b0;
        fired3 = 1'b0;
        if (rst) begin
            n_req0 -= q0.size();
            n_req3 -= q3.size();
            q0.delete();
            q3.delete();
        end else begin
            if (req_valid0 && req_ready0) begin
                q0.push_back(ref_resp(req_a, req_b, req_op, req_tag));
                n_req0++;
                fired0 = 1'b1;
            end
            if (req_valid3 && req_ready3) begin
                q3.push_back(ref_resp(req_a, req_b, req_op, req_tag));
                n_req3++;
                fired3 = 1'b1;
            end
            if (resp_valid0 && resp_ready) begin
                n_resp0++;
                checks++;
                assert (q0.size() > 0) else begin
                    errors++;
                    $error("FAIL resp0_unexpected: observed tag %0h expected no response", resp_tag0);
                end
                if (q0.size() > 0)
                    check("resp0", 64'({resp_result0, resp_tag0, resp_err0}), 64'(q0.pop_front()));
            end
            if (resp_valid3 && resp_ready) begin
                n_resp3++;
                checks++;
                assert (q3.size() > 0) else begin
                    errors++;
                    $error("FAIL resp3_unexpected: observed tag %0h expected no response", resp_tag3);
                end
                if (q3.size() > 0)
                    check("resp3", 64'({resp_result3, resp_tag3, resp_err3}), 64'(q3.pop_front()));
            end
        end
        @(posedge clk);
        #1;
        if (rand_rr) resp_ready = 1'($urandom_range(0, 1));
    endtask

    // Present a request and hold it until it fires; returns #1 after the fire edge.
    task automatic send(input bit sel3, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2:0] op, input logic [TW-1:0] tag);
        logic done;
        done    = 1'b0;
        req_a   = a;
        req_b   = b;
        req_op  = op;
        req_tag = tag;
        if (sel3) req_valid3 = 1'b1;
        else      req_valid0 = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            tick();
            done = sel3 ? fired3 : fired0;
        end
        check("send_fired", 64'(done), 64'd1);
        req_valid0 = 1'b0;
        req_valid3 = 1'b0;
    endtask

    task automatic drain();
        logic done;
        done       = 1'b0;
        rand_rr    = 1'b0;
        resp_ready = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            tick();
            done = (q0.size() == 0) && (q3.size() == 0) && !resp_valid0 && !resp_valid3;
        end
        check("drain_done", 64'(done), 64'd1);
    endtask

    initial begin
        rst        = 1'b1;
        req_valid0 = 1'b0;
        req_valid3 = 1'b0;
        resp_ready = 1'b0;
        req_a      = 32'd0;
        req_b      = 32'd0;
        req_op     = 3'b000;
        req_tag    = 4'd0;
        glitch     = 1'b0;
        rand_rr    = 1'b0;
        fired0     = 1'b0;
        fired3     = 1'b0;

        // Reset values while rst is held.
        repeat (3) tick();
        check("rst_req_ready0", 64'(req_ready0), 64'd0);
        check("rst_req_ready3", 64'(req_ready3), 64'd0);
        check("rst_busy0", 64'(busy0), 64'd0);
        check("rst_resp_valid0", 64'(resp_valid0), 64'd0);
        check("rst_resp_err0", 64'(resp_err0), 64'd0);
        check("rst_alu0", 64'({alu_a0, alu_op0}), 64'd0);
        check("rst_alu_b3", 64'(alu_b3), 64'd0);
        rst = 1'b0;
        tick();
        check("idle_req_ready0", 64'(req_ready0), 64'd1);

        // Basic GT with a combinational ALU.
        resp_ready = 1'b1;
        send(1'b0, 32'd5, 32'd3, 3'b010, 4'd2);
        check("basic_alu_a", 64'(alu_a0), 64'd5);
        check("basic_alu_b", 64'(alu_b0), 64'd3);
        check("basic_alu_op", 64'(alu_op0), 64'd2);
        check("basic_busy", 64'(busy0), 64'd1);
        check("basic_ready_wait", 64'(req_ready0), 64'd0);
        check("basic_early_valid", 64'(resp_valid0), 64'd0);
        tick();
        check("basic_resp", 64'({resp_valid0, resp_result0, resp_tag0, resp_err0}),
              64'({1'b1, 32'd1, 4'd2, 1'b0}));
        check("basic_b2b_ready", 64'(req_ready0), 64'd1);
        tick();
        check("basic_popped", 64'(resp_valid0), 64'd0);

        // Unsigned LT, order and tags preserved.
        send(1'b0, 32'hFFFF_FFFF, 32'd1, 3'b011, 4'd5);
        send(1'b0, 32'd1, 32'hFFFF_FFFF, 3'b011, 4'd6);
        drain();

        // Backpressure with a two-entry buffer.
        resp_ready = 1'b0;
        send(1'b0, 32'd10, 32'd3, 3'b010, 4'd1);
        send(1'b0, 32'd20, 32'd3, 3'b010, 4'd2);
        req_a      = 32'd30;
        req_b      = 32'd40;
        req_op     = 3'b010;
        req_tag    = 4'd3;
        req_valid0 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("bp_fired", 64'(fired0), 64'd0);
        end
        check("bp_ready_full", 64'(req_ready0), 64'd0);
        check("bp_head_stable", 64'({resp_valid0, resp_tag0}), 64'({1'b1, 4'd1}));
        resp_ready = 1'b1;
        for (int i = 0; i < 20 && !fired0; i++) tick();
        check("bp_tag3_fired", 64'(fired0), 64'd1);
        req_valid0 = 1'b0;
        drain();

        // Unsupported opcodes: zero result, err set, tag echoed.
        send(1'b0, 32'd9, 32'd4, 3'b000, 4'd7);
        send(1'b0, 32'd4, 32'd9, 3'b111, 4'd8);
        drain();

        // LATENCY=3 timing; alu_result is corrupted until the cycle before capture.
        send(1'b1, 32'd100, 32'd50, 3'b010, 4'd9);
        glitch = 1'b1;
        check("lat3_alu_c0", 64'({alu_a3, alu_op3}), 64'({32'd100, 3'b010}));
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (k == 3) glitch = 1'b0;
            if (k < 4) begin
                check("lat3_alu_stable", 64'({alu_a3, alu_op3}), 64'({32'd100, 3'b010}));
                check("lat3_alu_b", 64'(alu_b3), 64'd50);
                check("lat3_no_valid", 64'(resp_valid3), 64'd0);
            end else begin
                check("lat3_resp", 64'({resp_valid3, resp_result3, resp_tag3, resp_err3}),
                      64'({1'b1, 32'd1, 4'd9, 1'b0}));
            end
        end
        drain();

        // Reset in the middle of a LATENCY=3 wait drops the operation.
        send(1'b1, 32'd7, 32'd2, 3'b010, 4'd11);
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("rstmid_busy", 64'(busy3), 64'd0);
        check("rstmid_valid", 64'(resp_valid3), 64'd0);
        check("rstmid_alu", 64'({alu_a3, alu_b3, alu_op3}), 64'd0);
        check("rstmid_ready", 64'(req_ready3), 64'd0);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("rstmid_no_resp", 64'(resp_valid3), 64'd0);
        end

        // Randomized traffic on both instances with random backpressure.
        rand_rr = 1'b1;
        for (int i = 0; i < 60; i++) begin
            logic [W-1:0] a, b;
            logic [2:0]   op;
            a = $urandom();
            b = ($urandom_range(0, 3) == 0) ? a : $urandom();
            case ($urandom_range(0, 3))
                0:       op = 3'b010;
                1:       op = 3'b011;
                2:       op = 3'($urandom_range(0, 7));
                default: op = 3'b010;
            endcase
            send(1'($urandom_range(0, 1)), a, b, op, 4'($urandom_range(0, 15)));
        end
        drain();
        check("count_resp0", 64'(n_resp0), 64'(n_req0));
        check("count_resp3", 64'(n_resp3), 64'(n_req3));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
